// File: rtl/count_sequencer_pkg.sv
// Shared definitions for the count sequencer: controller state encoding.
package count_sequencer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/count_sequencer_tick_gen.sv
// Prescale divider: counts 0..PRESCALE-1 while enabled, tick is high on the last phase.
module tick_gen #(
  parameter int unsigned PRESCALE = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned W = $clog2(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] phase;

  assign tick = enable && (phase == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (enable) begin
      phase <= (phase == LAST) ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Run/stop/clear controller for counter16: strobe generation, terminal count, lap capture.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               clear_i,
  input  logic               lap_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic [CNT_W-1:0]   count_i,
  output logic               increment_o,
  output logic               counter_reset_o,
  output logic [CNT_W-1:0]   lap_o,
  output logic               lap_valid_o,
  output logic [STATE_W-1:0] state_o,
  output logic               done_o,
  output logic               overflow_o
);

  state_t state;
  logic   running;
  logic   limit_hit;
  logic   tick;

  assign running   = (state == RUN);
  assign limit_hit = (limit_i != '0) && (count_i == limit_i);
  assign state_o   = state;

  // Prescaler is held at 0 outside RUN, so every entry into RUN restarts the period.
  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (!running),
    .enable(running && !clear_i && !stop_i && !limit_hit),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      increment_o     <= 1'b0;
      counter_reset_o <= 1'b0;
      lap_o           <= '0;
      lap_valid_o     <= 1'b0;
      done_o          <= 1'b0;
      overflow_o      <= 1'b0;
    end else begin
      increment_o <= 1'b0;
      lap_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!clear_i && start_i) begin
            state           <= RUN;
            counter_reset_o <= 1'b1;
          end
        end
        RUN: begin
          if (clear_i) begin
            state           <= IDLE;
            counter_reset_o <= 1'b0;
          end else if (stop_i) begin
            state <= PAUSE;
          end else if (limit_hit) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else if (tick) begin
            increment_o <= 1'b1;
            if (count_i == '1) overflow_o <= 1'b1;
          end
        end
        PAUSE: begin
          if (clear_i) begin
            state           <= IDLE;
            counter_reset_o <= 1'b0;
          end else if (!stop_i && start_i) begin
            state <= RUN;
          end
        end
        DONE: begin
          if (clear_i) begin
            state           <= IDLE;
            done_o          <= 1'b0;
            counter_reset_o <= 1'b0;
          end
        end
      endcase
      // Lap is the lowest-priority command: any other command in the same cycle suppresses it.
      if (clear_i) begin
        lap_o      <= '0;
        overflow_o <= 1'b0;
      end else if (lap_i && !stop_i && !start_i && (state == RUN || state == PAUSE)) begin
        lap_o       <= count_i;
        lap_valid_o <= 1'b1;
      end
    end
  end

endmodule
